// File: rtl/sim_ctrl_pkg.sv
// Shared types for the simulation clock/reset/watchdog controller.
package sim_ctrl_pkg;

    typedef enum logic [2:0] {
        HOLD  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3,
        FAIL  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        WATCHDOG = 2'd1,
        GLOBAL   = 2'd2,
        IDLE     = 2'd3
    } fatal_e;

    localparam int unsigned DEF_CH_TIMEOUT     = 10000;
    localparam int unsigned DEF_GLOBAL_TIMEOUT = 1000000;
    localparam int unsigned DEF_QUIT_TIMEOUT   = 1000;

    // Channel-index width, never narrower than one bit.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sim_ctrl_ch_watchdog.sv
// Per-channel idle watchdog: counts cycles since the last activity pulse
// and flags expiry when the count reaches the configured timeout.
module sim_ctrl_ch_watchdog #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             active,
    input  logic             enable,
    input  logic             freeze,
    input  logic [CNT_W-1:0] timeout,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             armed;

    assign armed   = enable && (timeout != '0);
    assign cnt_nxt = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    // expired tracks the registered count, so it rises on the same edge the count reaches timeout
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else if (!freeze) begin
            if (active) begin
                cnt     <= '0;
                expired <= 1'b0;
            end else if (armed) begin
                cnt     <= cnt_nxt;
                expired <= (cnt_nxt == timeout);
            end else begin
                expired <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sim_ctrl_seq.sv
// Simulation controller: DUT reset/init sequencing, channel watchdogs, global
// timeout and quit/drain handshake. Optional trace window: SIM_CTRL_TRACE_WINDOW_EN.
module sim_ctrl_seq
    import sim_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned RESET_CYCLES = 5,
    parameter int unsigned INIT_CYCLES  = 1,
    localparam int unsigned CH_W        = ch_width(NUM_CH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] chActive,
    input  logic [NUM_CH-1:0] chEnable,
    input  logic [CNT_W-1:0]  chTimeout,
    input  logic [CNT_W-1:0]  globalTimeout,
    input  logic [CNT_W-1:0]  quitTimeout,
    input  logic              quitReq,
    input  logic              idle,
    input  logic [CNT_W-1:0]  dumpStart,
    input  logic [CNT_W-1:0]  dumpEnd,
    output logic              dutReset,
    output logic              initFlag,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  cycle,
    output logic              finish,
    output logic              fatal,
    output logic [1:0]        fatalCode,
    output logic [CH_W-1:0]   faultCh,
    output logic              dumpOn
);

    localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYCLES - 1);

    state_e            state_q;
    logic [CNT_W-1:0]  drain_cnt;
    logic [CNT_W-1:0]  drain_nxt;
    logic [CNT_W-1:0]  cycle_nxt;
    logic [NUM_CH-1:0] expired;
    logic              freeze;
    logic              wd_hit;
    logic [CH_W-1:0]   wd_ch;
    logic              global_hit;
    logic              drain_over;

    assign state      = state_q;
    assign freeze     = (state_q != RUN);
    assign cycle_nxt  = (cycle == '1) ? cycle : cycle + CNT_W'(1);
    assign drain_nxt  = (drain_cnt == '1) ? drain_cnt : drain_cnt + CNT_W'(1);
    assign global_hit = (globalTimeout != '0) && (cycle == globalTimeout);
    assign drain_over = (quitTimeout != '0) && (drain_nxt > quitTimeout);

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_wd
        sim_ctrl_ch_watchdog #(
            .CNT_W (CNT_W)
        ) u_wd (
            .clock   (clock),
            .reset   (reset),
            .active  (chActive[g]),
            .enable  (chEnable[g]),
            .freeze  (freeze),
            .timeout (chTimeout),
            .expired (expired[g])
        );
    end

    // Lowest expiring channel wins.
    always_comb begin
        wd_hit = |expired;
        wd_ch  = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (expired[i]) wd_ch = CH_W'(i);
        end
    end

`ifdef SIM_CTRL_TRACE_WINDOW_EN
    logic win_nxt;
    assign win_nxt = (cycle_nxt >= dumpStart) &&
                     ((dumpEnd == '0) || (cycle_nxt < dumpEnd));
`else
    logic unused_dump;
    assign unused_dump = ^{dumpStart, dumpEnd};
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= HOLD;
            dutReset  <= 1'b1;
            initFlag  <= 1'b1;
            cycle     <= '0;
            drain_cnt <= '0;
            finish    <= 1'b0;
            fatal     <= 1'b0;
            fatalCode <= NONE;
            faultCh   <= '0;
            dumpOn    <= 1'b0;
        end else begin
            cycle  <= cycle_nxt;
            finish <= 1'b0;
            fatal  <= 1'b0;
            if (cycle == INIT_LAST) initFlag <= 1'b0;
`ifdef SIM_CTRL_TRACE_WINDOW_EN
            dumpOn <= win_nxt;
`endif
            case (state_q)
                HOLD: begin
                    if (cycle == RESET_LAST) begin
                        dutReset <= 1'b0;
                        state_q  <= RUN;
                    end
                end
                // Priority: quit, then watchdog, then global timeout.
                RUN: begin
                    if (quitReq) begin
                        if (idle) begin
                            state_q <= DONE;
                            finish  <= 1'b1;
                            dumpOn  <= 1'b0;
                        end else begin
                            state_q   <= DRAIN;
                            drain_cnt <= '0;
                        end
                    end else if (wd_hit) begin
                        state_q   <= FAIL;
                        fatal     <= 1'b1;
                        fatalCode <= WATCHDOG;
                        faultCh   <= wd_ch;
                        dumpOn    <= 1'b0;
                    end else if (global_hit) begin
                        state_q   <= FAIL;
                        fatal     <= 1'b1;
                        fatalCode <= GLOBAL;
                        dumpOn    <= 1'b0;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_nxt;
                    if (idle) begin
                        state_q <= DONE;
                        finish  <= 1'b1;
                        dumpOn  <= 1'b0;
                    end else if (drain_over) begin
                        state_q   <= FAIL;
                        fatal     <= 1'b1;
                        fatalCode <= IDLE;
                        dumpOn    <= 1'b0;
                    end else if (global_hit) begin
                        state_q   <= FAIL;
                        fatal     <= 1'b1;
                        fatalCode <= GLOBAL;
                        dumpOn    <= 1'b0;
                    end
                end
                default: begin
                    dumpOn <= 1'b0;
                end
            endcase
        end
    end

endmodule
